serial_sub: RTL and testbench

Bit-serial unsigned subtractor computing `a - b` one bit per clock, LSB first, through a single full-adder cell with a registered carry. It is the inverse-operation companion to the team's full-adder datapath cell. It sits between a parallel operand source (switches/registers) and a result display, using a start/busy/done handshake. It trades N cycles of latency for one adder cell, regardless of width.

---
 rtl/serial_sub.sv | 125 ++++++++++++
 tb/tb_serial_sub.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: a - b computed LSB first as a + ~b + 1
// through one full-adder cell with a registered carry.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one difference bit per clock, N clocks total
module serial_sub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bo
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  logic [N-1:0]  r_sh_q, r_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bo_q, bo_d;

  logic          fa_a, fa_b, fa_s, fa_co;
  logic [N-1:0]  r_nxt;

  // Full-adder cell fed with the inverted subtrahend bit
  always_comb begin
    fa_a  = a_sh_q[0];
    fa_b  = ~b_sh_q[0];
    fa_s  = fa_a ^ fa_b ^ c_q;
    fa_co = (fa_a & fa_b) | (fa_a & c_q) | (fa_b & c_q);
    r_nxt = r_sh_q >> 1;
    r_nxt[N-1] = fa_s;
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        r_sh_d = r_nxt;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = fa_co;
        if (cnt_q == LAST) begin
          // Counter is parked at zero instead of wrapping past N-1
          cnt_d   = '0;
          diff_d  = r_nxt;
          bo_d    = ~fa_co;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bo   = bo_q;

endmodule

// File: tb/tb_serial_sub.sv
// Randomized and directed bench for serial_sub at N = 1, 8 and 16, checked
// against a plain modular-arithmetic reference.
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start1, start8, start16;
  logic [0:0]  a1, b1;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy1, busy8, busy16;
  logic        done1, done8, done16;
  logic [0:0]  diff1;
  logic [7:0]  diff8;
  logic [15:0] diff16;
  logic        bo1, bo8, bo16;

  int          total = 0;
  int          bad = 0;
  int          sel = 8;
  logic        cur_busy, cur_done, cur_bo;
  logic [15:0] cur_diff;

  always #5 clk = ~clk;

  serial_sub #(.N(1)) u_n1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bo(bo1));
  serial_sub #(.N(8)) u_n8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bo(bo8));
  serial_sub #(.N(16)) u_n16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .bo(bo16));

  always_comb begin
    cur_busy = busy8;
    cur_done = done8;
    cur_diff = {8'b0, diff8};
    cur_bo   = bo8;
    if (sel == 1) begin
      cur_busy = busy1;
      cur_done = done1;
      cur_diff = {15'b0, diff1};
      cur_bo   = bo1;
    end else if (sel == 16) begin
      cur_busy = busy16;
      cur_done = done16;
      cur_diff = diff16;
      cur_bo   = bo16;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: modular difference and unsigned less-than at width w
  task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] ed, output logic eb);
    int m, ea, ebv;
    m   = (1 << w) - 1;
    ea  = int'(av) & m;
    ebv = int'(bv) & m;
    ed  = 16'((ea - ebv) & m);
    eb  = (ea < ebv);
  endtask

  task automatic drive(input int w, input logic [15:0] av, input logic [15:0] bv, input logic st);
    case (w)
      1: begin a1 = av[0:0]; b1 = bv[0:0]; start1 = st; end
      16: begin a16 = av; b16 = bv; start16 = st; end
      default: begin a8 = av[7:0]; b8 = bv[7:0]; start8 = st; end
    endcase
  endtask

  task automatic run_op(input string tag, input int w, input logic [15:0] av, input logic [15:0] bv);
    logic [15:0] ed;
    logic        eb;
    int          lat, busy_cnt;
    logic        seen;
    sel = w;
    model(w, av, bv, ed, eb);
    @(negedge clk);
    drive(w, av, bv, 1'b1);
    @(negedge clk);
    drive(w, av, bv, 1'b0);
    lat = 1;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (cur_done) begin
        seen = 1'b1;
        break;
      end
      if (cur_busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(w + 1));
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(w));
    check({tag, ".busy_at_done"}, 32'(cur_busy), 32'd0);
    check({tag, ".diff"}, 32'(cur_diff), 32'(ed));
    check({tag, ".bo"}, 32'(cur_bo), 32'(eb));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(cur_done), 32'd0);
    check({tag, ".diff_held"}, 32'(cur_diff), 32'(ed));
  endtask

  initial begin
    logic [15:0] ra, rb, na, nb, ed;
    logic        eb;
    int          cnt, g;
    logic [15:0] got_d;
    logic        got_b;

    reset_n = 1'b0;
    drive(1, 16'd0, 16'd0, 1'b0);
    drive(8, 16'd0, 16'd0, 1'b0);
    drive(16, 16'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    for (int w = 1; w <= 16; w++) begin
      if (w == 1 || w == 8 || w == 16) begin
        sel = w;
        #1;
        check($sformatf("reset.n%0d.busy", w), 32'(cur_busy), 32'd0);
        check($sformatf("reset.n%0d.done", w), 32'(cur_done), 32'd0);
        check($sformatf("reset.n%0d.diff", w), 32'(cur_diff), 32'd0);
        check($sformatf("reset.n%0d.bo", w), 32'(cur_bo), 32'd0);
      end
    end
    reset_n = 1'b1;

    run_op("basic", 8, 16'd200, 16'd55);
    run_op("borrow", 8, 16'd5, 16'd9);
    run_op("zero_zero", 8, 16'd0, 16'd0);
    run_op("zero_one", 8, 16'd0, 16'd1);
    run_op("ff_ff", 8, 16'd255, 16'd255);
    run_op("n1_1m0", 1, 16'd1, 16'd0);
    run_op("n1_0m1", 1, 16'd0, 16'd1);
    run_op("n16_big", 16, 16'd1000, 16'd3000);
    for (int i = 0; i < 6; i++) begin
      run_op("rand8", 8, 16'($urandom), 16'($urandom));
      run_op("rand16", 16, 16'($urandom), 16'($urandom));
      run_op("rand1", 1, 16'($urandom), 16'($urandom));
    end

    // Mid-run start and operand changes must be ignored
    sel = 8;
    @(negedge clk);
    drive(8, 16'd100, 16'd30, 1'b1);
    @(negedge clk);
    drive(8, 16'd100, 16'd30, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drive(8, 16'd7, 16'd200, 1'b1);
    @(negedge clk);
    drive(8, 16'd7, 16'd200, 1'b0);
    cnt = 0;
    got_d = '0;
    got_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cur_done) begin
        cnt++;
        got_d = cur_diff;
        got_b = cur_bo;
      end
      @(negedge clk);
    end
    check("ignore_start.done_count", 32'(cnt), 32'd1);
    check("ignore_start.diff", 32'(got_d), 32'd70);
    check("ignore_start.bo", 32'(got_b), 32'd0);

    // Reset in cycle 4 of RUN aborts and clears the held result
    drive(8, 16'd200, 16'd55, 1'b1);
    @(negedge clk);
    drive(8, 16'd200, 16'd55, 1'b0);
    repeat (3) @(negedge clk);
    check("abort.busy_before", 32'(cur_busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort.busy", 32'(cur_busy), 32'd0);
    check("abort.done", 32'(cur_done), 32'd0);
    check("abort.diff", 32'(cur_diff), 32'd0);
    check("abort.bo", 32'(cur_bo), 32'd0);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cur_done || cur_busy) cnt++;
    end
    check("abort.quiet", 32'(cnt), 32'd0);
    run_op("after_abort", 8, 16'd77, 16'd78);

    // start held high: one result every N+1 cycles, operands swapped at each done
    sel = 8;
    ra = 16'($urandom_range(0, 255));
    rb = 16'($urandom_range(0, 255));
    @(negedge clk);
    drive(8, ra, rb, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      g = 1;
      while (!cur_done && g < 40) begin
        @(negedge clk);
        g++;
      end
      model(8, ra, rb, ed, eb);
      check($sformatf("b2b%0d.spacing", k), 32'(g), 32'd9);
      check($sformatf("b2b%0d.diff", k), 32'(cur_diff), 32'(ed));
      check($sformatf("b2b%0d.bo", k), 32'(cur_bo), 32'(eb));
      na = 16'($urandom_range(0, 255));
      nb = 16'($urandom_range(0, 255));
      drive(8, na, nb, (k < 4));
      ra = na;
      rb = nb;
      @(negedge clk);
    end
    check("b2b.idle_after", 32'(cur_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
